mem_wr_ctrl: RTL and testbench
==============================

# mem_wr_ctrl

Write-side controller for the 6C tag memory: the counterpart of the read-data mux that returns `TVAL` for word address 7 and NVM `DBO` otherwise. It accepts single-word write requests from the protocol engine. Writes to the `TVAL` address go to an internal register in one cycle. All other addresses run a timed NVM program pulse followed by a read-back verify, with bounded retry. It reports completion and error to the protocol engine.

## Interface
- `PROG_CYC`, 16: length of the NVM program pulse in clock cycles (≥1).
- `MAX_RETRY`, 2: extra program attempts after a failed verify (≥0).
- `TVAL_ADDR`, 6'h07: word address that maps to the `TVAL` register.
- `TVAL_RST`, 16'h0000: reset value of `TVAL`.

Ports:
- `DCLK` in 1: single clock, all logic on rising edge.
- `RST_N` in 1: asynchronous, active-low reset.
- `WR_REQ` in 1: write request, sampled in IDLE only.
- `WR_ADDR` in 6: target word address.
- `WR_DATA` in 16: word to write.
- `DBO` in 16: NVM read data, valid at the current `MEM_A`.
- `MEM_A` out 6: NVM address, latched request address.
- `MEM_DBI` out 16: NVM write data, latched request data.
- `MEM_PGM` out 1: NVM program strobe.
- `TVAL` out 16: `TVAL` register, also feeds the read mux.
- `WR_BUSY` out 1: high while an NVM write is in progress.
- `WR_DONE` out 1: one-cycle completion pulse.
- `WR_ERR` out 1: verify failure status, valid from the `WR_DONE` pulse onward.

## Operation
- States: IDLE, SETUP, PROG, VERIFY, DONE.
- **IDLE, `WR_REQ`=1, `WR_ADDR`==`TVAL_ADDR`:**
  - `TVAL` <= `WR_DATA` at that edge.
  - Next state DONE, `WR_ERR` <= 0.
  - `WR_BUSY` never asserts.
- **IDLE, `WR_REQ`=1, any other address:**
  - Latch `MEM_A` and `MEM_DBI`.
  - Clear the retry count and `WR_ERR`.
  - Next state SETUP.
- **SETUP:** one cycle, `MEM_PGM`=0; `MEM_A`/`MEM_DBI` are already stable. Next state PROG; load the pulse counter with `PROG_CYC`-1.
- **PROG:**
  - `MEM_PGM`=1.
  - Counter decrements each cycle.
  - At 0, next state is VERIFY. Total `MEM_PGM` high time is exactly `PROG_CYC` cycles.
- **VERIFY:** one cycle, `MEM_PGM`=0. Compare `DBO` with `MEM_DBI`.
  - Match: next state DONE.
  - Mismatch with retry count < `MAX_RETRY`: increment the retry count, next state SETUP.
  - Mismatch with retry count = `MAX_RETRY`: `WR_ERR` <= 1, next state DONE.
- **DONE:** `WR_DONE`=1 for one cycle, next state IDLE.
- `WR_REQ` outside IDLE (including during DONE) is ignored. No queuing; that request produces no `WR_DONE`.
- `TVAL` changes only on an accepted `TVAL_ADDR` write. NVM writes never modify it.
- `WR_BUSY` = (state ∈ {SETUP, PROG, VERIFY}).

## Timing
- **Reset values:**
  - State IDLE.
  - `MEM_A`=0, `MEM_DBI`=0, `MEM_PGM`=0.
  - `TVAL`=`TVAL_RST`.
  - `WR_BUSY`=0, `WR_DONE`=0, `WR_ERR`=0.
  - Counters 0.
- **Reset mid-operation:** `MEM_PGM` drops asynchronously with `RST_N` low. The aborted write gets no `WR_DONE`.
- **TVAL write:** accept edge N updates `TVAL` at N. `WR_DONE` is high during cycle N+1.
- **NVM write, first-pass success:**
  - Accept edge N; SETUP during cycle N+1.
  - PROG during cycles N+2 … N+1+`PROG_CYC`.
  - VERIFY during cycle N+2+`PROG_CYC`.
  - `WR_DONE` during cycle N+3+`PROG_CYC`.
- **Retries:** each retry adds `PROG_CYC`+2 cycles.
- **Next request:** the earliest acceptance is the edge after the `WR_DONE` cycle (back in IDLE).
- **Outputs:** all registered except `WR_BUSY`, which is decoded from registered state.
- **Widths:** the pulse counter is $clog2(`PROG_CYC`), minimum 1 bit. The retry counter is $clog2(`MAX_RETRY`+1), minimum 1 bit.

## Structure
- Shared package `rfid6c_mem_pkg` holds:
  - the `TVAL_ADDR` default;
  - the state enum (IDLE, SETUP, PROG, VERIFY, DONE);
  - the word/address width constants (16, 6), shared with the read-data mux.
- One sub-module, `prog_timer`: a loadable down-counter with a zero flag, parameterised by `PROG_CYC`. Everything else is in `mem_wr_ctrl`.

## Test plan
- **TVAL write:** reset, then `WR_REQ` with addr 6'h07, data 16'hBEEF → `TVAL`=16'hBEEF one edge later, `WR_DONE` 1 cycle, `WR_BUSY`/`MEM_PGM` never high, `WR_ERR`=0.
- **NVM write, pass:** addr 6'h02, data 16'h1234, NVM model returns the written data → `MEM_PGM` high exactly 16 cycles, `WR_DONE` at accept+19, `WR_ERR`=0, `TVAL` unchanged.
- **NVM write, retry then pass:** model fails verify once, then passes → two 16-cycle `MEM_PGM` pulses, `WR_DONE` at accept+37, `WR_ERR`=0.
- **NVM write, persistent fail:** `DBO` stuck at 16'h0000, data 16'h00FF → 3 pulses (`MAX_RETRY`=2), `WR_DONE` at accept+55 with `WR_ERR`=1. The next accepted request clears `WR_ERR`.
- **Busy-time request:** second `WR_REQ` (addr 6'h07, 16'hAAAA) during PROG → ignored, `TVAL` unchanged, exactly one `WR_DONE`.
- **Reset mid-PROG:** assert `RST_N`=0 in PROG cycle 5 → `MEM_PGM`=0 immediately, all outputs at reset values, no `WR_DONE` after release.

Source files
------------

// File: rtl/rfid6c_mem_pkg.sv
// Shared definitions for the 6C tag memory datapath.
// Used by both the write controller and the read-data mux.
package rfid6c_mem_pkg;

  localparam int WORD_W = 16;
  localparam int ADDR_W = 6;

  localparam logic [ADDR_W-1:0] TVAL_ADDR_DEF = 6'h07;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PROG,
    ST_VERIFY,
    ST_DONE
  } wr_state_t;

endpackage

// File: rtl/mem_wr_ctrl_prog_timer.sv
// NVM program-pulse timer: a loadable down-counter with a zero flag.
// It is loaded with PROG_CYC-1, so counting down to zero spans PROG_CYC cycles.
module prog_timer #(
  parameter int PROG_CYC = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic zero
);

  localparam int CW = (PROG_CYC > 1) ? $clog2(PROG_CYC) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(PROG_CYC - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mem_wr_ctrl.sv
// Write-side controller for the 6C tag memory.
// A write to TVAL_ADDR updates the TVAL register in one cycle; any other address
// runs an NVM program pulse followed by a read-back verify, with bounded retry.
//
//   state  | meaning
//   IDLE   | waiting for WR_REQ
//   SETUP  | address and data stable ahead of the pulse; timer loaded
//   PROG   | MEM_PGM high for PROG_CYC cycles
//   VERIFY | compare DBO with MEM_DBI; retry or finish
//   DONE   | one-cycle WR_DONE pulse
module mem_wr_ctrl
  import rfid6c_mem_pkg::*;
#(
  parameter int                 PROG_CYC  = 16,
  parameter int                 MAX_RETRY = 2,
  parameter logic [ADDR_W-1:0]  TVAL_ADDR = TVAL_ADDR_DEF,
  parameter logic [WORD_W-1:0]  TVAL_RST  = 16'h0000
) (
  input  logic              DCLK,
  input  logic              RST_N,
  input  logic              WR_REQ,
  input  logic [ADDR_W-1:0] WR_ADDR,
  input  logic [WORD_W-1:0] WR_DATA,
  input  logic [WORD_W-1:0] DBO,
  output logic [ADDR_W-1:0] MEM_A,
  output logic [WORD_W-1:0] MEM_DBI,
  output logic              MEM_PGM,
  output logic [WORD_W-1:0] TVAL,
  output logic              WR_BUSY,
  output logic              WR_DONE,
  output logic              WR_ERR
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  wr_state_t     state, state_nxt;
  logic [RW-1:0] retry_cnt;
  logic          tmr_load, tmr_en, tmr_zero;
  logic          accept_tval, accept_nvm, retry_inc, set_err;

  prog_timer #(.PROG_CYC(PROG_CYC)) u_prog_timer (
    .clk   (DCLK),
    .rst_n (RST_N),
    .load  (tmr_load),
    .en    (tmr_en),
    .zero  (tmr_zero)
  );

  always_comb begin
    state_nxt   = state;
    tmr_load    = 1'b0;
    tmr_en      = 1'b0;
    accept_tval = 1'b0;
    accept_nvm  = 1'b0;
    retry_inc   = 1'b0;
    set_err     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (WR_REQ) begin
          if (WR_ADDR == TVAL_ADDR) begin
            accept_tval = 1'b1;
            state_nxt   = ST_DONE;
          end else begin
            accept_nvm = 1'b1;
            state_nxt  = ST_SETUP;
          end
        end
      end
      ST_SETUP: begin
        tmr_load  = 1'b1;
        state_nxt = ST_PROG;
      end
      ST_PROG: begin
        tmr_en = 1'b1;
        if (tmr_zero) state_nxt = ST_VERIFY;
      end
      ST_VERIFY: begin
        if (DBO == MEM_DBI) begin
          state_nxt = ST_DONE;
        end else if (retry_cnt < RETRY_MAX) begin
          retry_inc = 1'b1;
          state_nxt = ST_SETUP;
        end else begin
          set_err   = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // MEM_PGM and WR_DONE are registered from the next state so they align with it.
  always_ff @(posedge DCLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ST_IDLE;
      retry_cnt <= '0;
      MEM_A     <= '0;
      MEM_DBI   <= '0;
      MEM_PGM   <= 1'b0;
      TVAL      <= TVAL_RST;
      WR_DONE   <= 1'b0;
      WR_ERR    <= 1'b0;
    end else begin
      state   <= state_nxt;
      MEM_PGM <= (state_nxt == ST_PROG);
      WR_DONE <= (state_nxt == ST_DONE);
      if (accept_tval) begin
        TVAL   <= WR_DATA;
        WR_ERR <= 1'b0;
      end
      if (accept_nvm) begin
        MEM_A     <= WR_ADDR;
        MEM_DBI   <= WR_DATA;
        retry_cnt <= '0;
        WR_ERR    <= 1'b0;
      end
      if (retry_inc) retry_cnt <= retry_cnt + 1'b1;
      if (set_err)   WR_ERR    <= 1'b1;
    end
  end

  assign WR_BUSY = (state == ST_SETUP) || (state == ST_PROG) || (state == ST_VERIFY);

endmodule

// File: tb/tb_mem_wr_ctrl.sv
// Testbench for mem_wr_ctrl: table of single-write vectors plus hand-written
// sequences for a request during PROG and a reset in the middle of PROG.
module tb_mem_wr_ctrl;

  logic        DCLK;
  logic        RST_N;
  logic        WR_REQ;
  logic [5:0]  WR_ADDR;
  logic [15:0] WR_DATA;
  logic [15:0] DBO;
  logic [5:0]  MEM_A;
  logic [15:0] MEM_DBI;
  logic        MEM_PGM;
  logic [15:0] TVAL;
  logic        WR_BUSY;
  logic        WR_DONE;
  logic        WR_ERR;

  mem_wr_ctrl dut (
    .DCLK    (DCLK),
    .RST_N   (RST_N),
    .WR_REQ  (WR_REQ),
    .WR_ADDR (WR_ADDR),
    .WR_DATA (WR_DATA),
    .DBO     (DBO),
    .MEM_A   (MEM_A),
    .MEM_DBI (MEM_DBI),
    .MEM_PGM (MEM_PGM),
    .TVAL    (TVAL),
    .WR_BUSY (WR_BUSY),
    .WR_DONE (WR_DONE),
    .WR_ERR  (WR_ERR)
  );

  initial DCLK = 1'b0;
  always #5 DCLK = ~DCLK;

  int errors = 0;
  int checks = 0;

  // NVM model: verify fails until more than fail_n pulses were seen, or always when stuck.
  int fail_n = 0;
  bit stuck  = 0;

  int ncyc = 0;
  int pgm_hi, pulses, done_cnt, done_at;
  bit pgm_prev, busy_seen, err_at_done;

  assign DBO = stuck ? 16'h0000 : ((pulses > fail_n) ? MEM_DBI : ~MEM_DBI);

  always @(negedge DCLK) begin
    ncyc++;
    if (MEM_PGM) pgm_hi++;
    if (MEM_PGM && !pgm_prev) pulses++;
    pgm_prev = MEM_PGM;
    if (WR_BUSY) busy_seen = 1'b1;
    if (WR_DONE) begin
      done_cnt++;
      if (done_cnt == 1) begin
        done_at     = ncyc;
        err_at_done = WR_ERR;
      end
    end
  end

  task automatic clear_mon();
    pgm_hi      = 0;
    pulses      = 0;
    done_cnt    = 0;
    done_at     = -1000;
    pgm_prev    = 1'b0;
    busy_seen   = 1'b0;
    err_at_done = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [5:0]  addr;
    logic [15:0] data;
    int          fail_n;
    bit          stuck;
    int          lat;
    int          pgm;
    int          pulses;
    bit          err;
    bit          busy;
    logic [15:0] tval;
  } vec_t;

  vec_t vecs[7];
  int   acc;

  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge DCLK); #1;
    stuck  = v.stuck;
    fail_n = v.fail_n;
    clear_mon();
    WR_REQ  = 1'b1;
    WR_ADDR = v.addr;
    WR_DATA = v.data;
    acc     = ncyc;
    @(posedge DCLK); #1;
    WR_REQ = 1'b0;
    if (v.addr == 6'h07) check({tag, " tval_next_edge"}, 32'(TVAL), 32'(v.data));
    repeat (64) @(negedge DCLK);
    #1;
    check({tag, " done_count"}, done_cnt, 1);
    check({tag, " latency"}, done_at - acc, v.lat);
    check({tag, " pgm_cycles"}, pgm_hi, v.pgm);
    check({tag, " pulses"}, pulses, v.pulses);
    check({tag, " err_at_done"}, 32'(err_at_done), 32'(v.err));
    check({tag, " err_hold"}, 32'(WR_ERR), 32'(v.err));
    check({tag, " busy_seen"}, 32'(busy_seen), 32'(v.busy));
    check({tag, " tval"}, 32'(TVAL), 32'(v.tval));
    if (v.addr != 6'h07) begin
      check({tag, " mem_a"}, 32'(MEM_A), 32'(v.addr));
      check({tag, " mem_dbi"}, 32'(MEM_DBI), 32'(v.data));
    end
  endtask

  initial begin
    //          addr   data      fn st lat pgm pl err busy tval
    vecs[0] = '{6'h07, 16'hBEEF, 0, 0, 1,  0,  0, 0, 0, 16'hBEEF};
    vecs[1] = '{6'h02, 16'h1234, 0, 0, 19, 16, 1, 0, 1, 16'hBEEF};
    vecs[2] = '{6'h05, 16'h5A5A, 1, 0, 37, 32, 2, 0, 1, 16'hBEEF};
    vecs[3] = '{6'h03, 16'h00FF, 0, 1, 55, 48, 3, 1, 1, 16'hBEEF};
    vecs[4] = '{6'h07, 16'h0042, 0, 0, 1,  0,  0, 0, 0, 16'h0042};
    vecs[5] = '{6'h04, 16'hFFFF, 0, 1, 55, 48, 3, 1, 1, 16'h0042};
    vecs[6] = '{6'h3F, 16'h0001, 0, 0, 19, 16, 1, 0, 1, 16'h0042};

    RST_N   = 1'b0;
    WR_REQ  = 1'b0;
    WR_ADDR = '0;
    WR_DATA = '0;
    clear_mon();
    #1;
    check("rst mem_a", 32'(MEM_A), 0);
    check("rst mem_dbi", 32'(MEM_DBI), 0);
    check("rst mem_pgm", 32'(MEM_PGM), 0);
    check("rst tval", 32'(TVAL), 0);
    check("rst busy", 32'(WR_BUSY), 0);
    check("rst done", 32'(WR_DONE), 0);
    check("rst err", 32'(WR_ERR), 0);
    repeat (3) @(negedge DCLK);
    #1 RST_N = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Request to TVAL_ADDR held from PROG cycle 4 through the DONE cycle is ignored.
    @(negedge DCLK); #1;
    stuck  = 1'b0;
    fail_n = 0;
    clear_mon();
    WR_REQ  = 1'b1;
    WR_ADDR = 6'h02;
    WR_DATA = 16'h1111;
    acc     = ncyc;
    @(posedge DCLK); #1;
    WR_REQ = 1'b0;
    repeat (5) @(negedge DCLK);
    #1;
    check("busy req in_prog", 32'(MEM_PGM), 1);
    WR_REQ  = 1'b1;
    WR_ADDR = 6'h07;
    WR_DATA = 16'hAAAA;
    repeat (14) @(negedge DCLK);
    #1;
    check("busy req done_now", 32'(WR_DONE), 1);
    WR_REQ = 1'b0;
    repeat (30) @(negedge DCLK);
    #1;
    check("busy req done_count", done_cnt, 1);
    check("busy req latency", done_at - acc, 19);
    check("busy req tval", 32'(TVAL), 32'h0042);
    check("busy req mem_a", 32'(MEM_A), 32'h02);
    check("busy req err", 32'(WR_ERR), 0);

    // Reset during PROG cycle 5.
    @(negedge DCLK); #1;
    clear_mon();
    WR_REQ  = 1'b1;
    WR_ADDR = 6'h06;
    WR_DATA = 16'h7777;
    acc     = ncyc;
    @(posedge DCLK); #1;
    WR_REQ = 1'b0;
    repeat (6) @(negedge DCLK);
    #1;
    check("midrst pgm_before", 32'(MEM_PGM), 1);
    RST_N = 1'b0;
    #1;
    check("midrst pgm", 32'(MEM_PGM), 0);
    check("midrst busy", 32'(WR_BUSY), 0);
    check("midrst mem_a", 32'(MEM_A), 0);
    check("midrst mem_dbi", 32'(MEM_DBI), 0);
    check("midrst tval", 32'(TVAL), 0);
    check("midrst done", 32'(WR_DONE), 0);
    check("midrst err", 32'(WR_ERR), 0);
    repeat (2) @(negedge DCLK);
    #1;
    clear_mon();
    RST_N = 1'b1;
    repeat (40) @(negedge DCLK);
    #1;
    check("midrst no_done", done_cnt, 0);
    check("midrst no_pgm", pgm_hi, 0);
    check("midrst no_busy", 32'(busy_seen), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
